if_fetch_queue: RTL

//   Instruction fetch queue and IF/ID boundary register. Sits directly downstream of the PC

---
 rtl/if_fetch_queue_if.sv | 30 +++
 rtl/if_fetch_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// IF -> ID fetch-queue bundle: fetch-side inputs, ID-side registered outputs and status.
interface if_fetch_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [5:0]        stall;
    logic              flush;
    logic              if_ce;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_valid;
    logic              stallreq_if;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow_err;

    modport master (
        output stall, flush, if_ce, if_pc, if_inst,
        input  id_pc, id_inst, id_valid, stallreq_if, fifo_count, overflow_err
    );

    modport slave (
        input  stall, flush, if_ce, if_pc, if_inst,
        output id_pc, id_inst, id_valid, stallreq_if, fifo_count, overflow_err
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue and IF/ID boundary register: buffers {pc, inst} pairs while
// decode stalls and presents one registered instruction per cycle to ID.
module if_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] id_pc_q;
    logic [INST_W-1:0] id_inst_q;
    logic              id_valid_q;
    logic              overflow_q;

    logic push_req;
    logic id_ready;
    logic empty;
    logic full;
    logic pop;
    logic bypass;
    logic wr_en;
    logic drop;

    // stall[0] and stall[5:3] belong to other pipeline stages
    logic unused_stall;
    assign unused_stall = &{1'b0, bus.stall[5:3], bus.stall[0]};

    // Queue control; push is gated by stall[1] so a held PC is captured only once
    always_comb begin
        push_req = bus.if_ce & ~bus.stall[1] & ~bus.flush;
        id_ready = ~bus.stall[2];
        empty    = (count == '0);
        full     = (count == CNT_W'(DEPTH));
        pop      = id_ready & ~empty;
        bypass   = id_ready & empty & push_req;
        wr_en    = push_req & ~bypass & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // Storage array carries no reset; validity is tracked by count and pointers
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= '{pc: bus.if_pc, inst: bus.if_inst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            // ID register: queue head first, then bypass of the live fetch, else bubble
            if (id_ready) begin
                if (pop) begin
                    id_pc_q    <= mem[rd_ptr].pc;
                    id_inst_q  <= mem[rd_ptr].inst;
                    id_valid_q <= 1'b1;
                end else if (bypass) begin
                    id_pc_q    <= bus.if_pc;
                    id_inst_q  <= bus.if_inst;
                    id_valid_q <= 1'b1;
                end else begin
                    id_pc_q    <= '0;
                    id_inst_q  <= '0;
                    id_valid_q <= 1'b0;
                end
            end
        end
    end

    // Stall request raised before the last free slot can be overrun
    assign bus.stallreq_if  = full | ((count == CNT_W'(DEPTH - 1)) & ~id_ready & push_req);
    assign bus.id_pc        = id_pc_q;
    assign bus.id_inst      = id_inst_q;
    assign bus.id_valid     = id_valid_q;
    assign bus.fifo_count   = count;
    assign bus.overflow_err = overflow_q;
endmodule
